// File: rtl/exmem_stage.sv
// EX/MEM pipeline register with a two-state data-memory handshake.
// Latches the EX instruction on every accept, drives the data-memory strobes
// while the access is outstanding, and stalls the front of the pipe until dhit.
module exmem_stage (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ex_valid,
    input  logic        ex_WEN,
    input  logic [4:0]  ex_wsel,
    input  logic [31:0] ex_outport,
    input  logic [31:0] ex_rtdat,
    input  logic        ex_memren,
    input  logic        ex_memwen,
    input  logic        ex_halt,
    input  logic        flush,
    input  logic        dhit,
    input  logic [31:0] dmemload,
    output logic        exm_valid,
    output logic        exm_WEN,
    output logic [4:0]  exm_wsel_out,
    output logic [31:0] exm_outport,
    output logic        dmemREN,
    output logic        dmemWEN,
    output logic [31:0] dmemaddr,
    output logic [31:0] dmemstore,
    output logic [31:0] exm_dload,
    output logic        exm_halt,
    output logic        mem_stall
);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t      state;
    logic        exm_memren;
    logic        exm_memwen;
    logic [31:0] exm_rtdat;

    logic accept;
    logic bubble;
    logic cap_load;
    logic cap_store;
    logic access_done;

    // Pipe advances when idle or when the outstanding access finishes this cycle.
    assign accept      = !exm_halt && ((state == IDLE) || ((state == ACCESS) && dhit));
    assign access_done = (state == ACCESS) && dhit;
    assign bubble      = flush || !ex_valid;
    // A simultaneous read and write request is treated as a store.
    assign cap_store   = ex_memwen;
    assign cap_load    = ex_memren && !ex_memwen;

    // NOTE: strobes are decoded from registered state only, so the asynchronous
    // reset of state drops them immediately without waiting for a clock edge.
    assign dmemREN   = (state == ACCESS) && exm_memren;
    assign dmemWEN   = (state == ACCESS) && exm_memwen;
    assign dmemaddr  = exm_outport;
    assign dmemstore = exm_rtdat;
    assign mem_stall = (state == ACCESS) && !dhit;

    // Pipeline register, load-data capture, sticky halt and access FSM.
    // NOTE: non-blocking assignments keep every register sampling the pre-edge
    // values, so the order of the statements below does not matter.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state        <= IDLE;
            exm_valid    <= 1'b0;
            exm_WEN      <= 1'b0;
            exm_wsel_out <= 5'd0;
            exm_outport  <= 32'd0;
            exm_rtdat    <= 32'd0;
            exm_memren   <= 1'b0;
            exm_memwen   <= 1'b0;
            exm_dload    <= 32'd0;
            exm_halt     <= 1'b0;
        end else begin
            if (access_done && exm_memren) begin
                exm_dload <= dmemload;
            end

            if (accept) begin
                if (bubble) begin
                    exm_valid    <= 1'b0;
                    exm_WEN      <= 1'b0;
                    exm_wsel_out <= 5'd0;
                    exm_outport  <= 32'd0;
                    exm_rtdat    <= 32'd0;
                    exm_memren   <= 1'b0;
                    exm_memwen   <= 1'b0;
                    state        <= IDLE;
                end else begin
                    exm_valid    <= 1'b1;
                    // Writes to R0 are never advertised to the forward unit.
                    exm_WEN      <= ex_WEN && (ex_wsel != 5'd0);
                    exm_wsel_out <= ex_wsel;
                    exm_outport  <= ex_outport;
                    exm_rtdat    <= ex_rtdat;
                    exm_memren   <= cap_load;
                    exm_memwen   <= cap_store;
                    exm_halt     <= ex_halt;
                    state        <= (cap_load || cap_store) ? ACCESS : IDLE;
                end
            end else if (access_done) begin
                // Halted with an access in flight: finish it, then park.
                state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_exmem_stage.sv
// Self-checking bench for exmem_stage: directed scenarios followed by random
// traffic, all compared against a transaction-level model of the stage.
module tb_exmem_stage;

    logic        CLK;
    logic        RST;
    logic        ex_valid;
    logic        ex_WEN;
    logic [4:0]  ex_wsel;
    logic [31:0] ex_outport;
    logic [31:0] ex_rtdat;
    logic        ex_memren;
    logic        ex_memwen;
    logic        ex_halt;
    logic        flush;
    logic        dhit;
    logic [31:0] dmemload;
    logic        exm_valid;
    logic        exm_WEN;
    logic [4:0]  exm_wsel_out;
    logic [31:0] exm_outport;
    logic        dmemREN;
    logic        dmemWEN;
    logic [31:0] dmemaddr;
    logic [31:0] dmemstore;
    logic [31:0] exm_dload;
    logic        exm_halt;
    logic        mem_stall;

    exmem_stage dut (
        .CLK         (CLK),
        .RST         (RST),
        .ex_valid    (ex_valid),
        .ex_WEN      (ex_WEN),
        .ex_wsel     (ex_wsel),
        .ex_outport  (ex_outport),
        .ex_rtdat    (ex_rtdat),
        .ex_memren   (ex_memren),
        .ex_memwen   (ex_memwen),
        .ex_halt     (ex_halt),
        .flush       (flush),
        .dhit        (dhit),
        .dmemload    (dmemload),
        .exm_valid   (exm_valid),
        .exm_WEN     (exm_WEN),
        .exm_wsel_out(exm_wsel_out),
        .exm_outport (exm_outport),
        .dmemREN     (dmemREN),
        .dmemWEN     (dmemWEN),
        .dmemaddr    (dmemaddr),
        .dmemstore   (dmemstore),
        .exm_dload   (exm_dload),
        .exm_halt    (exm_halt),
        .mem_stall   (mem_stall)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Transaction-level view of the instruction sitting in EX/MEM.
    typedef struct packed {
        logic        valid;
        logic        wen;
        logic [4:0]  wsel;
        logic [31:0] outport;
        logic [31:0] rtdat;
        logic        is_load;
        logic        is_store;
    } instr_t;

    instr_t      m_cur;
    logic        m_busy;     // memory op still outstanding
    logic [31:0] m_dload;
    logic        m_halted;

    int n_vectors = 0;
    int n_miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vectors++;
        if (obs !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cur    = '0;
        m_busy   = 1'b0;
        m_dload  = 32'd0;
        m_halted = 1'b0;
    endtask

    // Advance the model across one rising edge using the current inputs.
    task automatic model_edge();
        logic acc;
        if (RST) begin
            model_reset();
        end else begin
            acc = !m_halted && (!m_busy || dhit);
            if (m_busy && dhit && m_cur.is_load) m_dload = dmemload;
            if (acc) begin
                if (flush || !ex_valid) begin
                    m_cur  = '0;
                    m_busy = 1'b0;
                end else begin
                    m_cur.valid    = 1'b1;
                    m_cur.wen      = ex_WEN && (ex_wsel != 5'd0);
                    m_cur.wsel     = ex_wsel;
                    m_cur.outport  = ex_outport;
                    m_cur.rtdat    = ex_rtdat;
                    m_cur.is_store = ex_memwen;
                    m_cur.is_load  = ex_memren && !ex_memwen;
                    m_busy         = ex_memren || ex_memwen;
                    m_halted       = m_halted || ex_halt;
                end
            end else if (m_busy && dhit) begin
                m_busy = 1'b0;
            end
        end
    endtask

    task automatic compare_all();
        check("exm_valid", exm_valid, m_cur.valid);
        check("exm_WEN", exm_WEN, m_cur.wen);
        check("exm_wsel_out", exm_wsel_out, m_cur.wsel);
        check("exm_outport", exm_outport, m_cur.outport);
        check("dmemREN", dmemREN, m_busy && m_cur.is_load);
        check("dmemWEN", dmemWEN, m_busy && m_cur.is_store);
        check("mem_stall", mem_stall, m_busy && !dhit);
        check("exm_dload", exm_dload, m_dload);
        check("exm_halt", exm_halt, m_halted);
        if (m_busy) begin
            check("dmemaddr", dmemaddr, m_cur.outport);
            check("dmemstore", dmemstore, m_cur.rtdat);
        end
    endtask

    // Called in the low phase with inputs already set: compare, cross one
    // rising edge, and return at the following falling edge.
    task automatic step();
        if (RST) model_reset();
        #1;
        compare_all();
        model_edge();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic drive(input logic v, input logic wen, input logic [4:0] wsel,
                         input logic [31:0] outp, input logic [31:0] rt,
                         input logic ren, input logic mwen, input logic hlt,
                         input logic fl, input logic hit);
        ex_valid   = v;
        ex_WEN     = wen;
        ex_wsel    = wsel;
        ex_outport = outp;
        ex_rtdat   = rt;
        ex_memren  = ren;
        ex_memwen  = mwen;
        ex_halt    = hlt;
        flush      = fl;
        dhit       = hit;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        dmemload = 32'd0;
        step();
        step();
        RST = 1'b0;
    endtask

    task automatic randomize_inputs(input logic allow_halt);
        ex_valid   = ($urandom_range(0, 3) != 0);
        ex_WEN     = ($urandom_range(0, 1) != 0);
        ex_wsel    = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        ex_outport = $urandom;
        ex_rtdat   = $urandom;
        ex_memren  = ($urandom_range(0, 2) == 0);
        ex_memwen  = ($urandom_range(0, 3) == 0);
        ex_halt    = allow_halt && ($urandom_range(0, 63) == 0);
        flush      = ($urandom_range(0, 6) == 0);
        dhit       = ($urandom_range(0, 2) == 0);
        dmemload   = $urandom;
    endtask

    initial begin
        int ren_cnt;
        int stall_cnt;

        RST = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        dmemload = 32'd0;
        model_reset();
        @(negedge CLK);
        #1;
        check("reset_valid", exm_valid, 1'b0);
        check("reset_stall", mem_stall, 1'b0);
        do_reset();

        // ALU op writing R5: visible one cycle later with no stall.
        drive(1, 1, 5'd5, 32'h10, 32'h0, 0, 0, 0, 0, 0);
        step();
        check("alu_wen", exm_WEN, 1'b1);
        check("alu_wsel", exm_wsel_out, 32'd5);
        check("alu_outport", exm_outport, 32'h10);
        check("alu_stall", mem_stall, 1'b0);

        // Write to R0 is never advertised.
        drive(1, 1, 5'd0, 32'h20, 32'h0, 0, 0, 0, 0, 0);
        step();
        check("r0_wen", exm_WEN, 1'b0);

        // Load with three wait cycles, next instruction taken on the dhit edge.
        drive(1, 1, 5'd3, 32'h40, 32'h0, 1, 0, 0, 0, 0);
        step();
        drive(1, 1, 5'd7, 32'h77, 32'h0, 0, 0, 0, 0, 0);
        ren_cnt = 0;
        stall_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            dhit     = (i == 3);
            dmemload = (i == 3) ? 32'hDEADBEEF : $urandom;
            #1;
            ren_cnt   += int'(dmemREN);
            stall_cnt += int'(mem_stall);
            step();
        end
        check("load_ren_cycles", ren_cnt, 32'd4);
        check("load_stall_cycles", stall_cnt, 32'd3);
        check("load_dload", exm_dload, 32'hDEADBEEF);
        check("load_next_wsel", exm_wsel_out, 32'd7);

        // Flush while a store is pending is ignored; flush at the accept bubbles.
        drive(1, 0, 5'd0, 32'h80, 32'hCAFEF00D, 0, 1, 0, 0, 0);
        step();
        drive(1, 1, 5'd6, 32'h66, 32'h0, 0, 0, 0, 1, 0);
        step();
        check("store_wen_held", dmemWEN, 1'b1);
        check("store_data_held", dmemstore, 32'hCAFEF00D);
        check("store_valid_held", exm_valid, 1'b1);
        dhit = 1'b1;
        step();
        check("flush_bubble_valid", exm_valid, 1'b0);
        check("flush_bubble_wen", dmemWEN, 1'b0);

        // Halt behind a pending load: load completes, then the pipe freezes.
        drive(1, 1, 5'd2, 32'h100, 32'h0, 1, 0, 0, 0, 0);
        step();
        drive(1, 0, 5'd4, 32'h0, 32'h0, 0, 0, 1, 0, 0);
        step();
        check("halt_not_yet", exm_halt, 1'b0);
        dhit     = 1'b1;
        dmemload = 32'h12345678;
        step();
        check("halt_set", exm_halt, 1'b1);
        check("halt_load_done", exm_dload, 32'h12345678);
        drive(1, 1, 5'd9, 32'h99, 32'h0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step();
        check("halt_frozen_wsel", exm_wsel_out, 32'd4);
        check("halt_sticky", exm_halt, 1'b1);

        // Flush beats halt on the same accept.
        do_reset();
        drive(1, 0, 5'd1, 32'h0, 32'h0, 0, 0, 1, 1, 0);
        step();
        check("flush_halt", exm_halt, 1'b0);
        drive(1, 0, 5'd2, 32'h0, 32'h0, 0, 0, 0, 0, 0);
        step();
        check("flush_halt_next", exm_wsel_out, 32'd2);

        // Reset mid-access drops the strobe without a clock edge.
        drive(1, 1, 5'd8, 32'h200, 32'h0, 1, 0, 0, 0, 0);
        step();
        check("pre_reset_ren", dmemREN, 1'b1);
        #2;
        RST = 1'b1;
        #1;
        check("async_ren", dmemREN, 1'b0);
        check("async_stall", mem_stall, 1'b0);
        check("async_outport", exm_outport, 32'd0);
        check("async_wsel", exm_wsel_out, 32'd0);
        step();
        RST = 1'b0;

        // Random traffic with occasional halts and resets.
        for (int i = 0; i < 800; i++) begin
            randomize_inputs(1'b1);
            RST = ($urandom_range(0, 79) == 0);
            step();
        end
        RST = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule

// File: doc/exmem_stage.md
EXMEM_STAGE -- requirements
Module: exmem_stage

Interface
- REQ-001: CLK  in  1  system clock; all state updates on rising edge.
- REQ-002: RST  in  1  asynchronous, active-high reset.
- REQ-003: ex_valid  in  1  EX stage holds a real instruction.
- REQ-004: ex_WEN  in  1  instruction writes the register file.
- REQ-005: ex_wsel  in  5  destination register index.
- REQ-006: ex_outport  in  32  ALU result, also the memory address.
- REQ-007: ex_rtdat  in  32  store data, after forwarding.
- REQ-008: ex_memren / ex_memwen  in  1 each  load / store request.
- REQ-009: ex_halt  in  1  halt instruction.
- REQ-010: flush  in  1  replace the incoming instruction with a bubble.
- REQ-011: dhit  in  1  data memory completes the current request.
- REQ-012: dmemload  in  32  read data, valid when dhit is high.
- REQ-013: exm_valid, exm_WEN  out  1 each  latched valid; register-write enable for the forward unit.
- REQ-014: exm_wsel_out  out  5  latched destination index.
- REQ-015: exm_outport  out  32  latched ALU result.
- REQ-016: dmemREN, dmemWEN  out  1 each  memory request strobes.
- REQ-017: dmemaddr, dmemstore  out  32 each  memory address and store data.
- REQ-018: exm_dload  out  32  captured load data.
- REQ-019: exm_halt  out  1  sticky halt.
- REQ-020: mem_stall  out  1  freezes IF, ID and EX while high.

Function
- REQ-021: FSM states are IDLE and ACCESS.
- REQ-022: accept = !exm_halt && (state==IDLE || (state==ACCESS && dhit)).
- REQ-023: On the accept edge with flush=1 or ex_valid=0, the block shall load a bubble: valid, WEN, memren, memwen all 0; wsel 0; data fields 0.
- REQ-024: On any other accept edge, the block shall capture all ex_* fields, giving 1-cycle latency to the exm_* outputs.
- REQ-025: exm_WEN shall be captured as ex_WEN && ex_valid && (ex_wsel != 0); a write to R0 is never advertised.
- REQ-026: If ex_memren and ex_memwen are both 1, the block shall treat the instruction as a store and drop the read.
- REQ-027: After an accept that captures a load or store, next state shall be ACCESS; after any other accept, next state shall be IDLE.
- REQ-028: In ACCESS, dmemREN or dmemWEN shall follow the latched op, with dmemaddr = exm_outport and dmemstore = latched rtdat.
- REQ-029: In IDLE, all dmem strobes shall be 0; dmemaddr and dmemstore shall be don't-care.
- REQ-030: mem_stall = (state==ACCESS) && !dhit, combinational.
- REQ-031: The stall clears in the same cycle as dhit, and the next instruction is accepted on that same edge.
- REQ-032: In ACCESS with dhit and a latched load, exm_dload shall capture dmemload; otherwise exm_dload shall hold its value.
- REQ-033: While not accepting, all latched fields shall hold, and flush shall be ignored; an in-flight memory op always completes.
- REQ-034: When ex_halt is captured, exm_halt shall rise on that edge and stay 1 until reset.
- REQ-035: After halt, no further accepts occur, and a pending ACCESS still completes.
- REQ-036: A flush on the same accept edge as ex_halt shall win: no halt is recorded.
- REQ-037: dhit in IDLE shall be ignored.

Reset
- REQ-038: While RST=1, state shall be IDLE and every output register shall be 0, including exm_dload and exm_halt; mem_stall, dmemREN and dmemWEN shall be 0.
- REQ-039: A reset asserted during ACCESS shall abort the request immediately, with strobes low asynchronously.
- REQ-040: The first accept shall occur on the first rising edge after RST falls.

Verification
- REQ-041: ALU op ex_WEN=1, wsel=5, outport=0x10 -> next cycle exm_WEN=1, exm_wsel_out=5, exm_outport=0x10, mem_stall=0.
- REQ-042: Load to 0x40, dhit low for 3 cycles, then dmemload=0xDEADBEEF with dhit -> dmemREN=1 for 4 cycles, mem_stall=1 for 3, exm_dload=0xDEADBEEF, next instruction latched on the dhit edge.
- REQ-043: ex_WEN=1 with wsel=0 -> exm_WEN=0.
- REQ-044: flush during a pending store -> store completes with dmemWEN=1 and dmemstore unchanged; flush asserted at the following accept -> bubble with exm_valid=0.
- REQ-045: halt captured behind a pending load -> exm_halt=1, load completes, later ex_valid ignored.
- REQ-046: RST pulsed mid-ACCESS -> dmemREN drops without a clock edge, and all outputs are 0.
